// File: rtl/multi_alert_module.sv
// Multi-channel alert latch: debounced raise, latched alert, clear/acknowledge,
// mask and re-arm lockout per channel, plus aggregate status and event count.

// One alert channel: IDLE -> ARMING -> ALERT -> (HOLD) -> IDLE
module multi_alert_chan #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic mask,
  output logic q,
  output logic enter
);
  typedef enum logic [1:0] {IDLE, ARMING, ALERT, HOLD} state_e;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       raise;

  // next-state: b dominates everywhere, mask only gates new raises
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raise   = a & ~b & ~mask;
    case (state_q)
      IDLE: begin
        if (raise) begin
          if (DEBOUNCE == 1) begin
            state_d = ALERT;
            cnt_d   = 4'd0;
          end else begin
            state_d = ARMING;
            cnt_d   = 4'd1;
          end
        end
      end
      ARMING: begin
        if (raise) begin
          if (cnt_q + 4'd1 == DEB) begin
            state_d = ALERT;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      ALERT: begin
        // a still high at clear time means a stuck source: lock out re-arm
        if (b) state_d = a ? HOLD : IDLE;
      end
      HOLD: begin
        if (!a) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q     = (state_q == ALERT);
  assign enter = (state_d == ALERT) && (state_q != ALERT);
endmodule

// Top: channel array plus aggregate outputs
module multi_alert_module #(
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8,
  localparam int TW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  input  logic [CHANNELS-1:0] mask,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_bar,
  output logic                any_alert,
  output logic [TW-1:0]       top_id,
  output logic [CNT_W-1:0]    event_cnt
);
  localparam int SW = CNT_W + 5;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  logic [CHANNELS-1:0] enter;
  logic [4:0]          n_enter;
  logic [SW-1:0]       cnt_sum;
  logic [CNT_W-1:0]    event_cnt_q, event_cnt_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    multi_alert_chan #(.DEBOUNCE(DEBOUNCE)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .a     (a[i]),
      .b     (b[i]),
      .mask  (mask[i]),
      .q     (q[i]),
      .enter (enter[i])
    );
  end

  // count channels entering ALERT this edge; widened sum so clamp never wraps
  always_comb begin
    n_enter = 5'd0;
    for (int i = 0; i < CHANNELS; i++) n_enter = n_enter + 5'(enter[i]);
    cnt_sum     = SW'(event_cnt_q) + SW'(n_enter);
    event_cnt_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // saturating event counter
  always_ff @(posedge clk) begin
    if (rst) event_cnt_q <= '0;
    else     event_cnt_q <= event_cnt_d;
  end

  // lowest active index wins; scan downward so the last hit is the lowest
  always_comb begin
    top_id = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (q[i]) top_id = TW'(i);
    end
  end

  assign q_bar     = ~q;
  assign any_alert = |q;
  assign event_cnt = event_cnt_q;
endmodule

// File: tb/tb_multi_alert_module.sv
// Self-checking bench for multi_alert_module: directed scenarios plus random
// traffic, compared against a rule-level model of each channel.
module tb_multi_alert_module;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b, mask;
  logic [3:0] q, q_bar;
  logic       any_alert;
  logic [1:0] top_id;
  logic [7:0] event_cnt;

  // second instance for counter saturation
  logic       srst;
  logic [3:0] sa, sb, smask;
  logic [3:0] sq, sq_bar;
  logic       sany;
  logic [1:0] stop;
  logic [1:0] scnt;

  int n_cmp = 0;
  int n_fail = 0;

  // model: per channel latched flag, lockout flag and consecutive-raise streak
  bit m_alert[4];
  bit m_block[4];
  int m_streak[4];
  int m_events;

  localparam int DEB = 3;

  always #5 clk = ~clk;

  multi_alert_module #(.CHANNELS(4), .DEBOUNCE(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mask(mask), .q(q), .q_bar(q_bar),
    .any_alert(any_alert), .top_id(top_id), .event_cnt(event_cnt));

  multi_alert_module #(.CHANNELS(4), .DEBOUNCE(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(srst), .a(sa), .b(sb), .mask(smask), .q(sq), .q_bar(sq_bar),
    .any_alert(sany), .top_id(stop), .event_cnt(scnt));

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_alert[i] = 0; m_block[i] = 0; m_streak[i] = 0;
      end
      m_events = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_alert[i]) begin
          if (b[i]) begin
            m_alert[i] = 0;
            m_block[i] = a[i];
          end
        end else if (m_block[i]) begin
          if (!a[i]) m_block[i] = 0;
        end else if (a[i] && !b[i] && !mask[i]) begin
          m_streak[i]++;
          if (m_streak[i] == DEB) begin
            m_alert[i] = 1;
            m_streak[i] = 0;
            if (m_events < 255) m_events++;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
    end
  endtask

  function automatic logic [18:0] exp_vec();
    logic [3:0] eq;
    logic [1:0] tid;
    eq = '0;
    tid = '0;
    for (int i = 0; i < 4; i++) eq[i] = m_alert[i];
    for (int i = 3; i >= 0; i--) if (m_alert[i]) tid = 2'(i);
    return {eq, ~eq, |eq, tid, 8'(m_events)};
  endfunction

  // drive inputs, take one rising edge, advance model, settle to falling edge
  task automatic cycle(input logic [3:0] ia, input logic [3:0] ib,
                       input logic [3:0] im, input logic ir);
    a = ia; b = ib; mask = im; rst = ir;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(4'hF, 4'h0, 4'h0, 1'b1);
    cycle(4'hF, 4'h0, 4'h0, 1'b1);
    n_cmp++;
    if ({q, q_bar, any_alert, top_id, event_cnt} !== {4'h0, 4'hF, 1'b0, 2'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h",
               {q, q_bar, any_alert, top_id, event_cnt}, {4'h0, 4'hF, 1'b0, 2'd0, 8'd0});
    end
    for (int k = 1; k <= 3; k++) begin
      cycle(4'hF, 4'h0, 4'h0, 1'b0);
      n_cmp++;
      if (q !== ((k == 3) ? 4'hF : 4'h0)) begin
        n_fail++;
        $display("FAIL reset_release_edge%0d: got q=%h want %h", k, q, (k == 3) ? 4'hF : 4'h0);
      end
    end
    cycle(4'h0, 4'hF, 4'h0, 1'b0);
    cycle(4'h0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic test_debounce();
    for (int k = 0; k < 3; k++) begin
      cycle((k < 2) ? 4'b0010 : 4'b0000, 4'h0, 4'h0, 1'b0);
      n_cmp++;
      if (q !== 4'h0) begin
        n_fail++;
        $display("FAIL debounce_short: got q=%h want 0", q);
      end
    end
    for (int k = 0; k < 3; k++) cycle(4'b0010, 4'h0, 4'h0, 1'b0);
    n_cmp++;
    if ({q, top_id, event_cnt} !== {4'b0010, 2'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL debounce_full: got q=%h id=%0d cnt=%0d want q=2 id=1 cnt=1", q, top_id, event_cnt);
    end
  endtask

  task automatic test_clear_hold();
    cycle(4'b0010, 4'b0010, 4'h0, 1'b0);
    n_cmp++;
    if (q !== 4'h0) begin
      n_fail++;
      $display("FAIL clear: got q=%h want 0", q);
    end
    for (int k = 0; k < 4; k++) cycle(4'b0010, 4'h0, 4'h0, 1'b0);
    n_cmp++;
    if (q !== 4'h0) begin
      n_fail++;
      $display("FAIL hold_lockout: got q=%h want 0", q);
    end
    cycle(4'h0, 4'h0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(4'b0010, 4'h0, 4'h0, 1'b0);
    n_cmp++;
    if ({q, event_cnt} !== {4'b0010, 8'd2}) begin
      n_fail++;
      $display("FAIL rearm: got q=%h cnt=%0d want q=2 cnt=2", q, event_cnt);
    end
    cycle(4'h0, 4'b0010, 4'h0, 1'b0);
  endtask

  task automatic test_mask_priority();
    for (int k = 0; k < 5; k++) cycle(4'b0100, 4'h0, 4'b0100, 1'b0);
    n_cmp++;
    if (q !== 4'h0) begin
      n_fail++;
      $display("FAIL mask_block: got q=%h want 0", q);
    end
    for (int k = 0; k < 3; k++) cycle(4'b1001, 4'h0, 4'h0, 1'b0);
    n_cmp++;
    if ({q, top_id, event_cnt} !== {4'b1001, 2'd0, 8'd4}) begin
      n_fail++;
      $display("FAIL priority: got q=%h id=%0d cnt=%0d want q=9 id=0 cnt=4", q, top_id, event_cnt);
    end
    cycle(4'h0, 4'h0, 4'b0001, 1'b0);
    cycle(4'h0, 4'h0, 4'b0001, 1'b0);
    n_cmp++;
    if (q !== 4'b1001) begin
      n_fail++;
      $display("FAIL mask_latched: got q=%h want 9", q);
    end
    cycle(4'h0, 4'hF, 4'h0, 1'b0);
  endtask

  task automatic test_a_and_b();
    for (int k = 0; k < 5; k++) cycle(4'b0001, 4'b0001, 4'h0, 1'b0);
    n_cmp++;
    if ({q, q_bar, any_alert, top_id, event_cnt} !== exp_vec() || q[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL a_and_b: got %h want %h", {q, q_bar, any_alert, top_id, event_cnt}, exp_vec());
    end
  endtask

  task automatic test_saturation();
    srst = 1'b1; sa = 4'h0; sb = 4'h0;
    cycle(4'h0, 4'h0, 4'h0, 1'b0);
    srst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sa = 4'b0001; sb = 4'h0;
      cycle(4'h0, 4'h0, 4'h0, 1'b0);
      n_cmp++;
      if ({sq[0], scnt} !== {1'b1, 2'((k < 3) ? k : 3)}) begin
        n_fail++;
        $display("FAIL saturate_%0d: got q0=%b cnt=%0d want q0=1 cnt=%0d", k, sq[0], scnt, (k < 3) ? k : 3);
      end
      sa = 4'h0; sb = 4'b0001;
      cycle(4'h0, 4'h0, 4'h0, 1'b0);
    end
    srst = 1'b1; sb = 4'h0;
    cycle(4'h0, 4'h0, 4'h0, 1'b0);
    n_cmp++;
    if ({sq, scnt} !== {4'h0, 2'd0}) begin
      n_fail++;
      $display("FAIL saturate_reset: got q=%h cnt=%0d want 0/0", sq, scnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] ra, rb, rm;
    logic       rr;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i] = ($urandom % 4) != 0;
        rb[i] = ($urandom % 8) == 0;
        rm[i] = ($urandom % 8) == 0;
      end
      rr = ($urandom % 64) == 0;
      cycle(ra, rb, rm, rr);
      n_cmp++;
      if ({q, q_bar, any_alert, top_id, event_cnt} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_%0d: got %h want %h", k, {q, q_bar, any_alert, top_id, event_cnt}, exp_vec());
      end
    end
    cycle(4'h0, 4'h0, 4'h0, 1'b1);
    n_cmp++;
    if ({q, q_bar, any_alert, top_id, event_cnt} !== {4'h0, 4'hF, 1'b0, 2'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL final_reset: got %h", {q, q_bar, any_alert, top_id, event_cnt});
    end
  endtask

  initial begin
    a = '0; b = '0; mask = '0; rst = 1'b1;
    sa = '0; sb = '0; smask = '0; srst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_alert[i] = 0; m_block[i] = 0; m_streak[i] = 0;
    end
    m_events = 0;
    test_reset();
    test_debounce();
    test_clear_hold();
    test_mask_priority();
    test_a_and_b();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
